graph_id_feeder: RTL
====================

Name: graph_id_feeder

Overview:
- Ingress stage directly upstream of the contact-graph builder.
- Accepts raw agent IDs from the source over a valid/ready handshake and discards out-of-range and consecutive-duplicate IDs.
- Buffers surviving IDs in a small FIFO and presents them to the graph one at a time as a single-cycle data_rdy pulse with ID_in.
- Paces issue so a new ID is only sent after the graph reports data_vld for the previous one, or after a timeout.

Parameters:
- POPSIZE, 100, population size; legal IDs are 1..POPSIZE.
- ID_WIDTH, 11, width of an agent ID.
- FIFO_DEPTH, 8, ID buffer entries; power of two, at least 2.
- TIMEOUT, 16, maximum cycles to wait for graph data_vld after an issue.
- CNT_WIDTH, 8, width of the statistics counters.
- DEDUP, 1, 1 = drop an ID equal to the last accepted ID; 0 = disabled.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, active-low, synchronous.
- src_id  in  ID_WIDTH  raw ID from source.
- src_vld  in  1  src_id valid.
- src_rdy  out  1  feeder can accept; equals (fifo_count < FIFO_DEPTH).
- ID_in  out  ID_WIDTH  ID presented to graph.
- data_rdy  out  1  one-cycle issue strobe to graph.
- data_vld  in  1  graph finished processing the last ID.
- drop_cnt  out  CNT_WIDTH  IDs discarded by the filter; saturating.
- timeout_cnt  out  CNT_WIDTH  issues closed by timeout rather than data_vld; saturating.
- busy  out  1  high when the FIFO is non-empty or state != IDLE.

Behaviour:
- Reset (rst == 0 at a rising edge):
  - FIFO emptied; state = IDLE.
  - ID_in = 0, data_rdy = 0, drop_cnt = 0, timeout_cnt = 0, last_id = 0, wait counter = 0.
  - src_rdy = 1 after reset, since the FIFO is empty.
  - Reset mid-operation discards all buffered IDs and any pending wait, with no further data_rdy pulses.
- Handshake: a transfer occurs at a rising edge where src_vld && src_rdy. src_rdy is derived only from fifo_count; there is no same-cycle pop bypass, so a full FIFO refuses input even when popping that cycle.
- Filter (applied to every transferred ID):
  - Drop if src_id == 0 or src_id > POPSIZE.
  - Drop if DEDUP == 1 and src_id == last_id.
  - Otherwise push the ID and set last_id = src_id.
  - Dropped IDs still complete the handshake and increment drop_cnt, saturating at all-ones.
  - last_id is updated only on a push.
- FIFO: circular read/write pointers with wrap-around; count range 0..FIFO_DEPTH. Simultaneous push and pop leaves the count unchanged.
- Issue FSM:
  - IDLE: if the FIFO is non-empty -> ISSUE; otherwise stay.
  - ISSUE: lasts exactly one cycle.
    - data_rdy = 1; ID_in = FIFO head (registered); pop the head.
    - Clear the wait counter. -> WAIT.
  - WAIT: data_rdy = 0; the wait counter increments each cycle.
    - data_vld == 1 -> IDLE.
    - Otherwise, when the wait counter reaches TIMEOUT-1 -> IDLE and increment timeout_cnt (saturating).
    - data_vld takes priority over timeout in the same cycle.
- data_vld is ignored in IDLE and ISSUE.
- ID_in holds its value after the pulse until the next ISSUE.
- Latency with an empty FIFO and state IDLE:
  - ID transferred at edge t -> ISSUE entered at edge t+1.
  - data_rdy high for the cycle between edges t+1 and t+2; the graph samples it at edge t+2.
- Minimum spacing between data_rdy pulses is 3 cycles (ISSUE, WAIT with immediate data_vld, IDLE).
- Width rules: comparisons are unsigned on ID_WIDTH bits. POPSIZE must be below 2**ID_WIDTH.

Test Plan:
- Reset, then push 1, 2, 3 with the graph model returning data_vld 4 cycles after each data_rdy -> three data_rdy pulses carrying ID_in = 1, 2, 3 in order. The first pulse is sampled 2 edges after the first transfer. drop_cnt = 0, timeout_cnt = 0.
- Push 0, 101, 2047, 50 -> only 50 issued; drop_cnt = 3.
- DEDUP = 1, push 2, 2, 3, 2 -> issued 2, 3, 2; drop_cnt = 1. Repeat with DEDUP = 0 -> issued 2, 2, 3, 2; drop_cnt = 0.
- Hold data_vld low, push 8 then 12 IDs continuously:
  - src_rdy drops while count = 8.
  - Each issue ends after TIMEOUT cycles; timeout_cnt increments per issue.
  - All 12 IDs are issued in order across pointer wrap-around, and none are lost.
- Assert data_vld in the same cycle the wait counter reaches TIMEOUT-1 -> return to IDLE with timeout_cnt unchanged.
- Apply rst = 0 for one cycle while in WAIT with 5 IDs buffered:
  - Next cycle: busy = 0, src_rdy = 1, counters = 0, ID_in = 0.
  - No data_rdy pulses until new input arrives.

Source files
------------

// File: rtl/graph_id_feeder_if.sv
// Source and graph handshake bundle for the ID feeder.
// The slave side belongs to the feeder, and the master side belongs to whatever drives it.
interface graph_id_feeder_if #(
  parameter int ID_WIDTH = 11
);
  logic [ID_WIDTH-1:0] src_id;
  logic                src_vld;
  logic                src_rdy;
  logic [ID_WIDTH-1:0] ID_in;
  logic                data_rdy;
  logic                data_vld;

  modport slave (
    input  src_id, src_vld, data_vld,
    output src_rdy, ID_in, data_rdy
  );

  modport master (
    output src_id, src_vld, data_vld,
    input  src_rdy, ID_in, data_rdy
  );
endinterface

// File: rtl/graph_id_feeder.sv
// Ingress feeder for the contact-graph builder: filters raw agent IDs, buffers them,
// and issues them one at a time, paced by the graph's data_vld or by a timeout.
module graph_id_feeder #(
  parameter int POPSIZE    = 100,
  parameter int ID_WIDTH   = 11,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 8,
  parameter int DEDUP      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  graph_id_feeder_if.slave     bus,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic [CNT_WIDTH-1:0] timeout_cnt,
  output logic                 busy
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t               state_q;
  logic [ID_WIDTH-1:0]  id_in_q;
  logic                 data_rdy_q;
  logic [WAIT_W-1:0]    wait_q;
  logic [CNT_WIDTH-1:0] timeout_cnt_q;

  logic [ID_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ID_WIDTH-1:0]  last_id_q, last_id_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic src_rdy, xfer, in_range, dup, push, drop, pop;

  // src_rdy depends only on occupancy, so a full FIFO refuses input even on a pop cycle
  assign src_rdy  = (count_q < CNT_W'(FIFO_DEPTH));
  assign xfer     = bus.src_vld && src_rdy;
  assign in_range = (bus.src_id != '0) && (bus.src_id <= ID_WIDTH'(POPSIZE));
  assign dup      = (DEDUP != 0) && (bus.src_id == last_id_q);
  assign push     = xfer && in_range && !dup;
  assign drop     = xfer && !push;
  assign pop      = (state_q == ISSUE);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    last_id_d  = last_id_q;
    drop_cnt_d = drop_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.src_id;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      last_id_d       = bus.src_id;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_id_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_id_q  <= last_id_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is payload only; occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // The head is latched on entry to ISSUE and popped on leaving it, so the two always refer to the same entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      id_in_q       <= '0;
      data_rdy_q    <= 1'b0;
      wait_q        <= '0;
      timeout_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            state_q    <= ISSUE;
            data_rdy_q <= 1'b1;
            id_in_q    <= mem_q[rd_ptr_q];
          end
        end
        ISSUE: begin
          data_rdy_q <= 1'b0;
          wait_q     <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (bus.data_vld) begin
            state_q <= IDLE;
          end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
            state_q <= IDLE;
            if (timeout_cnt_q != '1) timeout_cnt_q <= timeout_cnt_q + CNT_WIDTH'(1);
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          data_rdy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.src_rdy  = src_rdy;
  assign bus.ID_in    = id_in_q;
  assign bus.data_rdy = data_rdy_q;
  assign drop_cnt     = drop_cnt_q;
  assign timeout_cnt  = timeout_cnt_q;
  assign busy         = (count_q != '0) || (state_q != IDLE);
endmodule
